// File: rtl/spi_master_frame_collector_pkg.sv
// Shared types for the SPI master frame collector: FSM states, frame flags and the frame record.
package spi_master_frame_collector_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        TAIL = 3'd4,
        EMIT = 3'd5
    } state_e;

    localparam logic [1:0] FLAG_CMD   = 2'd0;
    localparam logic [1:0] FLAG_ADDR  = 2'd1;
    localparam logic [1:0] FLAG_DATA  = 2'd2;
    localparam logic [1:0] FLAG_ABORT = 2'd3;

    typedef struct packed {
        logic [31:0] cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] bits;
        logic [1:0]  flag;
    } frame_s;

    // First field in CMD -> ADDR -> DATA order whose length is non-zero.
    function automatic state_e first_field(input logic cmd_nz, input logic addr_nz, input logic data_nz);
        if (cmd_nz) return CMD;
        if (addr_nz) return ADDR;
        if (data_nz) return DATA;
        return TAIL;
    endfunction

endpackage

// File: rtl/spi_master_frame_collector_pin_sync.sv
// Synchronizes the three SPI pins into HCLK and derives SCLK/CSn edge strobes.
// With SPI_MASTER_FRAME_COLLECTOR_TIMEOUT_EN an SCLK falling strobe is also provided.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic i_sclk,
    input  logic i_csn,
    input  logic i_mosi,
    output logic o_sclk_rise,
    output logic o_csn_fall,
    output logic o_csn_rise,
    output logic o_mosi_s
`ifdef SPI_MASTER_FRAME_COLLECTOR_TIMEOUT_EN
    ,
    output logic o_sclk_fall
`endif
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_csn_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_csn_d;

    // CSn chain resets to its idle level so leaving reset never fakes a chip-select edge.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_sclk_sync <= '0;
            r_csn_sync  <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_csn_d     <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], i_csn};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_csn_d     <= r_csn_sync[SYNC_STAGES-1];
        end
    end

    assign o_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_d;
    assign o_csn_fall  = ~r_csn_sync[SYNC_STAGES-1] & r_csn_d;
    assign o_csn_rise  = r_csn_sync[SYNC_STAGES-1] & ~r_csn_d;
    assign o_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
`ifdef SPI_MASTER_FRAME_COLLECTOR_TIMEOUT_EN
    assign o_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_d;
`endif

endmodule

// File: rtl/spi_master_frame_collector.sv
// Passive SPI master pad monitor: rebuilds each CSn-bounded transfer into a cmd/addr/data frame.
// Optional SCLK-idle abort enabled by SPI_MASTER_FRAME_COLLECTOR_TIMEOUT_EN.
module spi_master_frame_collector
    import spi_master_frame_collector_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_FIELD_W = 32
`ifdef SPI_MASTER_FRAME_COLLECTOR_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        spi_sclk,
    input  logic        spi_csn,
    input  logic        spi_mosi,
    input  logic [5:0]  cfg_cmd_len,
    input  logic [5:0]  cfg_addr_len,
    input  logic [15:0] cfg_data_len,
    output logic        frm_valid,
    input  logic        frm_ready,
    output logic [31:0] frm_cmd,
    output logic [31:0] frm_addr,
    output logic [31:0] frm_data,
    output logic [31:0] frm_bits,
    output logic [1:0]  frm_flag,
    output logic        overrun,
    output logic [2:0]  dbg_state
);

    logic w_sclk_rise, w_csn_fall, w_csn_rise, w_mosi;
    logic w_take, w_abort, w_timeout;
    logic w_cmd_nz, w_addr_nz, w_data_nz;
    logic [15:0] w_next_len;
    state_e r_state, w_state_next;

    logic [5:0]             r_cmd_len, r_addr_len;
    logic [15:0]            r_data_len;
    logic [15:0]            r_cnt;
    logic [MAX_FIELD_W-1:0] r_cmd, r_addr, r_data;
    logic [31:0]            r_bits;
    logic                   r_abort;
    frame_s                 r_out;
    logic                   r_valid, r_overrun;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .i_sclk      (spi_sclk),
        .i_csn       (spi_csn),
        .i_mosi      (spi_mosi),
        .o_sclk_rise (w_sclk_rise),
        .o_csn_fall  (w_csn_fall),
        .o_csn_rise  (w_csn_rise),
        .o_mosi_s    (w_mosi)
`ifdef SPI_MASTER_FRAME_COLLECTOR_TIMEOUT_EN
        ,
        .o_sclk_fall (w_sclk_fall)
`endif
    );

`ifdef SPI_MASTER_FRAME_COLLECTOR_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic            w_sclk_fall;
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge HCLK) begin
        if (!HRESETn || r_state == IDLE || r_state == EMIT || w_sclk_rise || w_sclk_fall) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) && !w_sclk_rise && !w_sclk_fall;
`else
    assign w_timeout = 1'b0;
`endif

    // In IDLE the lengths come straight from cfg_*; afterwards only the copies latched at CSn fall count.
    always_comb begin
        w_cmd_nz   = (r_state == IDLE) ? (cfg_cmd_len != '0)  : (r_cmd_len != '0);
        w_addr_nz  = (r_state == IDLE) ? (cfg_addr_len != '0) : (r_addr_len != '0);
        w_data_nz  = (r_state == IDLE) ? (cfg_data_len != '0) : (r_data_len != '0);
        w_next_len = '0;
        case (w_state_next)
            CMD:     w_next_len = (r_state == IDLE) ? 16'(cfg_cmd_len)  : 16'(r_cmd_len);
            ADDR:    w_next_len = (r_state == IDLE) ? 16'(cfg_addr_len) : 16'(r_addr_len);
            DATA:    w_next_len = (r_state == IDLE) ? cfg_data_len      : r_data_len;
            default: w_next_len = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_csn_fall) w_state_next = first_field(w_cmd_nz, w_addr_nz, w_data_nz);
            end
            CMD, ADDR, DATA: begin
                if (w_csn_rise || w_timeout) begin
                    w_state_next = EMIT;
                    w_abort      = 1'b1;
                end else if (w_sclk_rise) begin
                    w_take = 1'b1;
                    if (r_cnt == 16'd1) begin
                        case (r_state)
                            CMD:     w_state_next = first_field(1'b0, w_addr_nz, w_data_nz);
                            ADDR:    w_state_next = first_field(1'b0, 1'b0, w_data_nz);
                            default: w_state_next = TAIL;
                        endcase
                    end
                end
            end
            TAIL: begin
                if (w_csn_rise || w_timeout) begin
                    w_state_next = EMIT;
                    w_abort      = w_timeout;
                end else if (w_sclk_rise) begin
                    w_take = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_cmd_len  <= '0;
            r_addr_len <= '0;
            r_data_len <= '0;
            r_cnt      <= '0;
            r_cmd      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_bits     <= '0;
            r_abort    <= 1'b0;
            r_out      <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (r_state == IDLE && w_csn_fall) begin
                r_cmd_len  <= cfg_cmd_len;
                r_addr_len <= cfg_addr_len;
                r_data_len <= cfg_data_len;
                r_cmd      <= '0;
                r_addr     <= '0;
                r_data     <= '0;
                r_bits     <= '0;
                r_abort    <= 1'b0;
            end
            if (w_take) begin
                r_bits <= r_bits + 32'd1;
                case (r_state)
                    CMD:     r_cmd  <= {r_cmd[MAX_FIELD_W-2:0], w_mosi};
                    ADDR:    r_addr <= {r_addr[MAX_FIELD_W-2:0], w_mosi};
                    DATA:    r_data <= {r_data[MAX_FIELD_W-2:0], w_mosi};
                    default: ;
                endcase
            end
            if (w_state_next != r_state && w_state_next inside {CMD, ADDR, DATA}) begin
                r_cnt <= w_next_len;
            end else if (w_take && r_state != TAIL) begin
                r_cnt <= r_cnt - 16'd1;
            end
            if (w_state_next == EMIT) r_abort <= w_abort;

            // A transfer in the same cycle frees the slot, so the new frame replaces it without overrun.
            if (r_state == EMIT) begin
                if (!r_valid || frm_ready) begin
                    r_out.cmd  <= 32'(r_cmd);
                    r_out.addr <= 32'(r_addr);
                    r_out.data <= 32'(r_data);
                    r_out.bits <= r_bits;
                    r_out.flag <= r_abort            ? FLAG_ABORT :
                                  (r_data_len != '0) ? FLAG_DATA  :
                                  (r_addr_len != '0) ? FLAG_ADDR  : FLAG_CMD;
                    r_valid    <= 1'b1;
                end else begin
                    r_overrun  <= 1'b1;
                end
            end else if (r_valid && frm_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign frm_valid = r_valid;
    assign frm_cmd   = r_out.cmd;
    assign frm_addr  = r_out.addr;
    assign frm_data  = r_out.data;
    assign frm_bits  = r_out.bits;
    assign frm_flag  = r_out.flag;
    assign overrun   = r_overrun;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_master_frame_collector.sv
// Self-checking bench for spi_master_frame_collector: directed and random SPI frames against a reference model.
module tb_spi_master_frame_collector;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_csn = 1'b1;
    logic        spi_mosi = 1'b0;
    logic [5:0]  cfg_cmd_len = '0;
    logic [5:0]  cfg_addr_len = '0;
    logic [15:0] cfg_data_len = '0;
    logic        frm_ready = 1'b0;
    logic        frm_valid;
    logic [31:0] frm_cmd, frm_addr, frm_data, frm_bits;
    logic [1:0]  frm_flag;
    logic        overrun;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [129:0] exp_q[$];   // {cmd, addr, data, bits, flag}
    logic         tx_q[$];    // MOSI bits of the frame being sent, MSB first
    logic         ready_low = 1'b1;

    spi_master_frame_collector dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .spi_sclk     (spi_sclk),
        .spi_csn      (spi_csn),
        .spi_mosi     (spi_mosi),
        .cfg_cmd_len  (cfg_cmd_len),
        .cfg_addr_len (cfg_addr_len),
        .cfg_data_len (cfg_data_len),
        .frm_valid    (frm_valid),
        .frm_ready    (frm_ready),
        .frm_cmd      (frm_cmd),
        .frm_addr     (frm_addr),
        .frm_data     (frm_data),
        .frm_bits     (frm_bits),
        .frm_flag     (frm_flag),
        .overrun      (overrun),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 HCLK = ~HCLK;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(frm_valid), 32'd0);
        check({tag, "_cmd"}, frm_cmd, 32'd0);
        check({tag, "_addr"}, frm_addr, 32'd0);
        check({tag, "_data"}, frm_data, 32'd0);
        check({tag, "_bits"}, frm_bits, 32'd0);
        check({tag, "_flag"}, 32'(frm_flag), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] field_value(input int start, input int len, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = start; i < start + len && i < n; i++) v = v * 2 + 64'(tx_q[i]);
        return v[31:0];
    endfunction

    function automatic logic [129:0] model(input int c, input int a, input int d, input int n);
        logic [31:0] cmd, addr, data;
        logic [1:0]  flag;
        cmd  = field_value(0, c, n);
        addr = field_value(c, a, n);
        data = field_value(c + a, d, n);
        if (n < c + a + d) flag = 2'd3;
        else if (d > 0)    flag = 2'd2;
        else if (a > 0)    flag = 2'd1;
        else               flag = 2'd0;
        return {cmd, addr, data, 32'(n), flag};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_field(input logic [31:0] v, input int len);
        logic [31:0] t;
        t = v;
        for (int i = len - 1; i >= 0; i--) tx_q.push_back(t[i]);
    endtask

    task automatic push_rand(input int len);
        for (int i = 0; i < len; i++) tx_q.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic spi_frame(input int c, input int a, input int d, input int n,
                             input bit expect_out, input bit scramble, input bit reset_mid);
        cfg_cmd_len  = 6'(c);
        cfg_addr_len = 6'(a);
        cfg_data_len = 16'(d);
        if (expect_out) exp_q.push_back(model(c, a, d, n));
        wait_cyc(2);
        spi_csn = 1'b0;
        wait_cyc(6);
        if (scramble) begin
            cfg_cmd_len  = 6'($urandom_range(0, 32));
            cfg_addr_len = 6'($urandom_range(0, 32));
            cfg_data_len = 16'($urandom_range(0, 200));
        end
        for (int i = 0; i < n; i++) begin
            spi_mosi = tx_q[i];
            wait_cyc(4);
            spi_sclk = 1'b1;
            wait_cyc(4);
            spi_sclk = 1'b0;
        end
        wait_cyc(4);
        if (reset_mid) begin
            HRESETn = 1'b0;
            wait_cyc(2);
            check_outputs_zero("reset_mid");
            spi_csn = 1'b1;
            wait_cyc(4);
            HRESETn = 1'b1;
        end else begin
            spi_csn = 1'b1;
        end
        wait_cyc(12);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            wait_cyc(1);
            k++;
        end
        check({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- ready driver ----------------
    initial begin
        forever begin
            @(posedge HCLK);
            #1;
            frm_ready = ready_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [129:0] e;
        forever begin
            @(negedge HCLK);
            if (HRESETn && frm_valid && frm_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got cmd 0x%08h bits %0d with none expected", frm_cmd, frm_bits);
                end else begin
                    e = exp_q.pop_front();
                    check("frm_cmd", frm_cmd, e[129:98]);
                    check("frm_addr", frm_addr, e[97:66]);
                    check("frm_data", frm_data, e[65:34]);
                    check("frm_bits", frm_bits, e[33:2]);
                    check("frm_flag", 32'(frm_flag), 32'(e[1:0]));
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [129:0] first;
        int c, a, d, total, n, mode;

        wait_cyc(3);
        check_outputs_zero("reset");
        HRESETn = 1'b1;
        wait_cyc(2);
        ready_low = 1'b0;

        // Full 8/32/32 frame
        tx_q.delete();
        push_field(32'h0B, 8); push_field(32'h1C008000, 32); push_field(32'hDEADBEEF, 32);
        spi_frame(8, 32, 32, 72, 1'b1, 1'b0, 1'b0);

        // Command-only frame
        tx_q.delete();
        push_field(32'h9F, 8);
        spi_frame(8, 0, 0, 8, 1'b1, 1'b0, 1'b0);

        // Abort after 20 edges: cmd complete, 12 address bits
        tx_q.delete();
        push_field(32'hA5, 8); push_field(32'h123456, 24); push_field(32'h0, 32);
        spi_frame(8, 24, 32, 20, 1'b1, 1'b0, 1'b0);

        // 64-bit data field keeps the last 32 bits
        tx_q.delete();
        push_field(32'h03, 8); push_field(32'h00001000, 32);
        push_field(32'h12345678, 32); push_field(32'hCAFEF00D, 32);
        spi_frame(8, 32, 64, 104, 1'b1, 1'b0, 1'b0);
        drain("directed");
        check("overrun_before", 32'(overrun), 32'd0);

        // Output held: second frame dropped, overrun set
        ready_low = 1'b1;
        wait_cyc(2);
        tx_q.delete();
        push_field(32'h5A, 8); push_field(32'h0000BEEF, 16);
        spi_frame(8, 16, 0, 24, 1'b1, 1'b0, 1'b0);
        first = exp_q[0];
        tx_q.delete();
        push_field(32'hC3, 8); push_field(32'h00001111, 16);
        spi_frame(8, 16, 0, 24, 1'b0, 1'b0, 1'b0);
        check("hold_valid", 32'(frm_valid), 32'd1);
        check("hold_cmd", frm_cmd, first[129:98]);
        check("hold_addr", frm_addr, first[97:66]);
        check("hold_bits", frm_bits, first[33:2]);
        check("overrun_set", 32'(overrun), 32'd1);
        ready_low = 1'b0;
        drain("overrun");
        wait_cyc(10);
        check("second_dropped", 32'(frm_valid), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset mid-address, then a clean frame
        tx_q.delete();
        push_rand(72);
        spi_frame(8, 32, 32, 20, 1'b0, 1'b0, 1'b1);
        check_outputs_zero("after_reset");
        tx_q.delete();
        push_field(32'h0B, 8); push_field(32'h1C008004, 32); push_field(32'h600DF00D, 32);
        spi_frame(8, 32, 32, 72, 1'b1, 1'b0, 1'b0);
        drain("reset");

        // Random frames, with cfg changed mid-frame
        for (int k = 0; k < 10; k++) begin
            c = $urandom_range(1, 32);
            a = $urandom_range(0, 32);
            d = $urandom_range(0, 80);
            total = c + a + d;
            mode = $urandom_range(0, 2);
            if (mode == 0)      n = total;
            else if (mode == 1) n = total + $urandom_range(1, 5);
            else                n = $urandom_range(0, total - 1);
            tx_q.delete();
            push_rand(total + 5);
            spi_frame(c, a, d, n, 1'b1, 1'b1, 1'b0);
        end
        drain("random");
        check("overrun_random", 32'(overrun), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
